// File: rtl/fifo_pkg.sv
// Shared types and constants for the FIFO access controller and its arbiter.
package fifo_pkg;

  localparam int unsigned FIFO_DW    = 4;
  localparam int unsigned FIFO_DEPTH = 8;
  localparam int unsigned FIFO_CW    = 4;

  // Round-robin order is W0 -> W1 -> RD -> W0.
  typedef enum logic [1:0] {
    REQ_W0 = 2'd0,
    REQ_W1 = 2'd1,
    REQ_RD = 2'd2
  } req_id_t;

  // Matches the FIFO wnr polarity.
  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  function automatic req_id_t next_req(input req_id_t id);
    case (id)
      REQ_W0:  return REQ_W1;
      REQ_W1:  return REQ_RD;
      default: return REQ_W0;
    endcase
  endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin arbiter: searches from ptr_i, grants the first eligible
// requester and points just past it; the pointer holds when nothing is granted.
module rr_arb3 import fifo_pkg::*; (
  input  logic [2:0] elig_i,
  input  req_id_t    ptr_i,
  output logic [2:0] gnt_o,
  output req_id_t    ptr_next_o
);

  req_id_t cand;

  always_comb begin
    gnt_o      = 3'b000;
    ptr_next_o = ptr_i;
    cand       = ptr_i;
    for (int k = 0; k < 3; k++) begin
      if (gnt_o == 3'b000 && elig_i[cand]) begin
        gnt_o[cand] = 1'b1;
        ptr_next_o  = next_req(cand);
      end
      cand = next_req(cand);
    end
  end

endmodule

// File: rtl/fifo_access_ctrl.sv
// Shares one single-port FIFO between two writers and one reader, one command
// per cycle, with a local occupancy count cross-checked against the FIFO flags.
module fifo_access_ctrl import fifo_pkg::*; #(
  parameter int unsigned DW    = FIFO_DW,
  parameter int unsigned DEPTH = FIFO_DEPTH,
  parameter int unsigned CW    = FIFO_CW
) (
  input  logic          clk_d,
  input  logic          rst,
  input  logic          wr0_req,
  input  logic [DW-1:0] wr0_data,
  output logic          wr0_ack,
  input  logic          wr1_req,
  input  logic [DW-1:0] wr1_data,
  output logic          wr1_ack,
  input  logic          rd_req,
  output logic          rd_ack,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          fifo_en,
  output logic          fifo_wnr,
  output logic [DW-1:0] fifo_d_in,
  input  logic [DW-1:0] fifo_d_out,
  input  logic          fifo_full,
  input  logic          fifo_empty,
  output logic [CW-1:0] count,
  output logic          err
);

  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  logic [CW-1:0] count_q, count_d;
  req_id_t       ptr_q, ptr_d, ptr_nxt;
  logic          en_q, en_d;
  logic          wnr_q, wnr_d;
  logic [DW-1:0] din_q, din_d;
  logic          rd_valid_q, rd_valid_d;
  logic          err_q, err_d;
  logic [2:0]    elig, gnt;
  logic          wr_gnt;

  // Gating eligibility with rst keeps acks low throughout reset.
  always_comb begin
    elig[0] = rst && wr0_req && (count_q < DepthC);
    elig[1] = rst && wr1_req && (count_q < DepthC);
    elig[2] = rst && rd_req && (count_q != '0);
  end

  rr_arb3 u_arb (
    .elig_i     (elig),
    .ptr_i      (ptr_q),
    .gnt_o      (gnt),
    .ptr_next_o (ptr_nxt)
  );

  assign wr0_ack = gnt[0];
  assign wr1_ack = gnt[1];
  assign rd_ack  = gnt[2];
  assign wr_gnt  = gnt[0] | gnt[1];

  always_comb begin
    count_d = count_q;
    ptr_d   = ptr_nxt;
    en_d    = |gnt;
    wnr_d   = wnr_q;
    din_d   = din_q;
    if (wr_gnt) begin
      count_d = count_q + 1'b1;
      wnr_d   = OP_WRITE;
      din_d   = gnt[1] ? wr1_data : wr0_data;
    end else if (gnt[2]) begin
      count_d = count_q - 1'b1;
      wnr_d   = OP_READ;
    end
    // A read issued last cycle has its data on fifo_d_out this cycle.
    rd_valid_d = en_q && (wnr_q == OP_READ);
    // Flags only agree with count when no command is still in flight.
    err_d = err_q | (!en_q && ((fifo_full != (count_q == DepthC)) ||
                               (fifo_empty != (count_q == '0))));
  end

  always_ff @(posedge clk_d) begin
    if (!rst) begin
      count_q    <= '0;
      ptr_q      <= REQ_W0;
      en_q       <= 1'b0;
      wnr_q      <= OP_READ;
      din_q      <= '0;
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_d;
      ptr_q      <= ptr_d;
      en_q       <= en_d;
      wnr_q      <= wnr_d;
      din_q      <= din_d;
      rd_valid_q <= rd_valid_d;
      err_q      <= err_d;
    end
  end

  assign count     = count_q;
  assign fifo_en   = en_q;
  assign fifo_wnr  = wnr_q;
  assign fifo_d_in = din_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = fifo_d_out;
  assign err       = err_q;

  a_gnt_onehot: assert property (@(posedge clk_d) disable iff (!rst) $onehot0(gnt));
  a_no_overflow: assert property (@(posedge clk_d) disable iff (!rst)
                                  wr_gnt |-> (count_q != DepthC));
  a_no_underflow: assert property (@(posedge clk_d) disable iff (!rst)
                                   gnt[2] |-> (count_q != '0));

endmodule

// File: tb/tb_fifo_access_ctrl.sv
// Bench for fifo_access_ctrl: behavioural FIFO, per-cycle reference model and
// directed phases (reset, fill, drain, fairness, mid-op reset, flag checker).
module tb_fifo_access_ctrl;

  logic       clk_d = 1'b0;
  logic       rst = 1'b0;
  logic       wr0_req = 1'b0, wr1_req = 1'b0, rd_req = 1'b0;
  logic [3:0] wr0_data = 4'd1, wr1_data = 4'hA;
  logic       wr0_ack, wr1_ack, rd_ack, rd_valid;
  logic [3:0] rd_data, fifo_d_in, fifo_d_out;
  logic       fifo_en, fifo_wnr, fifo_full, fifo_empty, err;
  logic [3:0] count;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  always #5 clk_d = ~clk_d;
  always @(posedge clk_d) cyc <= cyc + 1;

  fifo_access_ctrl dut (
    .clk_d      (clk_d),
    .rst        (rst),
    .wr0_req    (wr0_req),
    .wr0_data   (wr0_data),
    .wr0_ack    (wr0_ack),
    .wr1_req    (wr1_req),
    .wr1_data   (wr1_data),
    .wr1_ack    (wr1_ack),
    .rd_req     (rd_req),
    .rd_ack     (rd_ack),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .fifo_en    (fifo_en),
    .fifo_wnr   (fifo_wnr),
    .fifo_d_in  (fifo_d_in),
    .fifo_d_out (fifo_d_out),
    .fifo_full  (fifo_full),
    .fifo_empty (fifo_empty),
    .count      (count),
    .err        (err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural 8-entry FIFO sharing the controller's reset.
  logic [3:0] bq[$];
  int         b_size = 0;
  logic       bad_empty = 1'b0;
  initial fifo_d_out = 4'd0;
  always @(posedge clk_d) begin
    if (!rst) begin
      bq.delete();
      fifo_d_out <= 4'd0;
    end else if (fifo_en) begin
      if (fifo_wnr) bq.push_back(fifo_d_in);
      else if (bq.size() > 0) fifo_d_out <= bq.pop_front();
    end
    b_size = bq.size();
  end
  assign fifo_full  = (b_size == 8);
  assign fifo_empty = (b_size == 0) ^ bad_empty;

  // Reference model: state for the current cycle, advanced once per cycle.
  int         m_cnt = 0, m_ptr = 0;
  logic       m_en = 0, m_wnr = 0, m_rv = 0, m_pend = 0, m_err = 0;
  logic [3:0] m_din = 0, m_rdata = 0, m_pdata = 0;
  logic [3:0] m_q[$];

  always @(negedge clk_d) begin
    logic [2:0] el, eg;
    int g, i;
    el[0] = rst && wr0_req && (m_cnt < 8);
    el[1] = rst && wr1_req && (m_cnt < 8);
    el[2] = rst && rd_req && (m_cnt > 0);
    g = -1;
    for (int k = 0; k < 3; k++) begin
      i = (m_ptr + k) % 3;
      if (g < 0 && el[i]) g = i;
    end
    eg = 3'b000;
    if (g >= 0) eg[g] = 1'b1;
    chk("acks", {rd_ack, wr1_ack, wr0_ack}, eg);
    chk("count", count, m_cnt);
    chk("fifo_en", fifo_en, m_en);
    chk("fifo_wnr", fifo_wnr, m_wnr);
    chk("fifo_d_in", fifo_d_in, m_din);
    chk("rd_valid", rd_valid, m_rv);
    if (m_rv) chk("rd_data", rd_data, m_rdata);
    chk("err", err, m_err);
    if (!rst) begin
      m_cnt = 0; m_ptr = 0; m_en = 0; m_wnr = 0; m_din = 0;
      m_rv = 0; m_pend = 0; m_err = 0;
      m_q.delete();
    end else begin
      if (!m_en && ((fifo_full != (m_cnt == 8)) || (fifo_empty != (m_cnt == 0)))) m_err = 1;
      m_rv    = m_pend;
      m_rdata = m_pdata;
      m_pend  = 0;
      m_en    = (g >= 0);
      if (g == 0 || g == 1) begin
        m_wnr = 1;
        m_din = (g == 0) ? wr0_data : wr1_data;
        m_q.push_back(m_din);
        m_cnt++;
      end else if (g == 2) begin
        m_wnr   = 0;
        m_pdata = m_q.pop_front();
        m_pend  = 1;
        m_cnt--;
      end
      if (g >= 0) m_ptr = (g + 1) % 3;
    end
  end

  // Read-data log for the drain phase.
  logic [3:0] rv_data[$];
  int         rv_cyc[$];
  always @(negedge clk_d) begin
    if (rd_valid) begin
      rv_data.push_back(rd_data);
      rv_cyc.push_back(cyc);
    end
  end

  // One cycle: drive requests, sample acks mid-cycle, advance producer data.
  task automatic step(input logic r0, input logic r1, input logic rr,
                      output logic [2:0] acks, output int ack_cyc);
    wr0_req = r0;
    wr1_req = r1;
    rd_req  = rr;
    @(negedge clk_d);
    acks    = {rd_ack, wr1_ack, wr0_ack};
    ack_cyc = cyc;
    @(posedge clk_d);
    #1;
    if (acks[0]) wr0_data = wr0_data + 4'd1;
    if (acks[1]) wr1_data = wr1_data + 4'd1;
  endtask

  logic [2:0] a;
  int         c, n_ack, first_ack;
  logic [2:0] order[6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};

  initial begin
    @(posedge clk_d);
    #1;
    // Reset with every request high.
    rst = 1'b0;
    step(1, 1, 1, a, c);
    chk("rst_acks0", a, 0);
    step(1, 1, 1, a, c);
    chk("rst_acks1", a, 0);
    chk("rst_en", fifo_en, 0);
    chk("rst_count", count, 0);
    chk("rst_err", err, 0);
    rst = 1'b1;
    step(1, 1, 1, a, c);
    chk("first_grant_w0", a, 3'b001);
    rst = 1'b0;
    step(0, 0, 0, a, c);
    rst = 1'b1;
    wr0_data = 4'd1;

    // Fill with 1..8 from W0; the ninth request stays unacked.
    n_ack = 0;
    for (int k = 0; k < 9; k++) begin
      step(1, 0, 0, a, c);
      if (a[0]) begin
        n_ack++;
        chk("fill_d_in", fifo_d_in, k + 1);
      end
    end
    chk("fill_acks", n_ack, 8);
    chk("fill_last_ack", a, 0);
    chk("fill_count", count, 8);
    chk("fill_full", fifo_full, 1);
    chk("fill_err", err, 0);

    // Drain.
    rv_data.delete();
    rv_cyc.delete();
    n_ack = 0;
    first_ack = -1;
    for (int k = 0; k < 10; k++) begin
      step(0, 0, 1, a, c);
      if (a[2]) begin
        n_ack++;
        if (first_ack < 0) first_ack = c;
      end
    end
    chk("drain_acks", n_ack, 8);
    chk("drain_nvalid", rv_data.size(), 8);
    for (int k = 0; k < 8; k++) begin
      if (k < rv_data.size()) begin
        chk("drain_data", rv_data[k], k + 1);
        chk("drain_cycle", rv_cyc[k], first_ack + 2 + k);
      end
    end
    chk("drain_count", count, 0);
    chk("drain_empty", fifo_empty, 1);
    chk("drain_no_ack", a, 0);

    // Fairness from count 4 with the pointer back at W0.
    for (int k = 0; k < 5; k++) step(1, 0, 0, a, c);
    step(0, 0, 1, a, c);
    chk("fair_start_count", count, 4);
    for (int k = 0; k < 6; k++) begin
      step(1, 1, 1, a, c);
      chk("fair_order", a, order[k]);
    end
    chk("fair_count6", count, 6);
    for (int k = 0; k < 10; k++) step(1, 1, 1, a, c);
    chk("fair_count_end", count, 8);

    // Reset in the cycle after a read ack.
    step(0, 0, 1, a, c);
    chk("mid_read_ack", a, 3'b100);
    rst = 1'b0;
    step(0, 0, 0, a, c);
    chk("mid_rd_valid", rd_valid, 0);
    chk("mid_fifo_en", fifo_en, 0);
    rst = 1'b1;
    step(0, 0, 0, a, c);
    chk("mid_count", count, 0);
    chk("mid_empty", fifo_empty, 1);

    // Flag checker: wrong empty flag while idle sets a sticky err.
    bad_empty = 1'b1;
    step(0, 0, 0, a, c);
    chk("chk_err_set", err, 1);
    bad_empty = 1'b0;
    for (int k = 0; k < 3; k++) step(0, 0, 0, a, c);
    chk("chk_err_sticky", err, 1);
    rst = 1'b0;
    step(0, 0, 0, a, c);
    chk("chk_err_clear", err, 0);
    rst = 1'b1;
    step(0, 0, 0, a, c);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fifo_access_ctrl.md
Name: fifo_access_ctrl

Overview:
Arbiter/sequencer that shares the single-port 8x4 FIFO (single wnr control, one access per clock) between two write producers and one read consumer. It issues at most one FIFO command per cycle and tracks FIFO occupancy locally, so grants never overflow or underflow the FIFO. It checks that local count against the FIFO's full/empty flags. It sits directly in front of the FIFO instance and drives its wnr, enable and d_in.

Parameters:
DW, 4, data width of FIFO entries and producer/consumer data.
DEPTH, 8, FIFO capacity in entries; sets the local count range 0..DEPTH.
CW, 4, local count width; must satisfy 2^CW > DEPTH.

Ports:
clk_d  in  1  single clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
wr0_req  in  1  producer 0 write request; held with wr0_data until acked
wr0_data  in  DW  producer 0 write data
wr0_ack  out  1  combinational grant; transfer occurs when req&&ack at the clock edge
wr1_req  in  1  producer 1 write request
wr1_data  in  DW  producer 1 write data
wr1_ack  out  1  producer 1 grant
rd_req  in  1  consumer read request
rd_ack  out  1  consumer grant
rd_valid  out  1  registered; read data is valid this cycle
rd_data  out  DW  equals fifo_d_out; meaningful only when rd_valid=1
fifo_en  out  1  registered; FIFO performs an access this cycle
fifo_wnr  out  1  registered; 1=write, 0=read
fifo_d_in  out  DW  registered write data to FIFO
fifo_d_out  in  DW  FIFO read data (registered inside FIFO)
fifo_full  in  1  FIFO full flag
fifo_empty  in  1  FIFO empty flag
count  out  CW  local occupancy 0..DEPTH
err  out  1  sticky flag mismatch

Behaviour:
- Reset (rst=0 at an edge) sets: count=0, rr pointer=W0, fifo_en=0, fifo_wnr=0, fifo_d_in=0, rd_valid=0, err=0. Acks are forced to 0 while rst=0.
- Reset mid-operation drops any in-flight command and pending rd_valid. The FIFO's rst must be driven from the same reset.
- Eligibility, evaluated combinationally each cycle N:
  - W0 is eligible if wr0_req && count<DEPTH.
  - W1 is eligible if wr1_req && count<DEPTH.
  - R is eligible if rd_req && count>0.
- Round-robin over the order W0 -> W1 -> R. Search starts at the pointer; the first eligible requester gets the grant. Exactly one ack is high, or none.
- The pointer moves to the requester after the granted one. It holds when no grant is made.
- Grant in cycle N, effects at the edge ending N:
  - Write grant: fifo_en=1, fifo_wnr=1, fifo_d_in=granted data in cycle N+1; count+1.
  - Read grant: fifo_en=1, fifo_wnr=0 in N+1; count-1.
  - No grant: fifo_en=0 in N+1 and fifo_wnr holds its previous value.
- Read latency: rd_ack in N, FIFO read in N+1, rd_valid=1 with rd_data=fifo_d_out in N+2, for exactly one cycle per granted read.
- Back-to-back: a requester holding req high may be acked on consecutive cycles whenever the rotation returns to it. Throughput is 1 command/cycle total.
- Full boundary: at count==DEPTH, writers are never acked and a pending read still wins. A read and a write can never share a cycle.
- Empty boundary: at count==0, rd_ack=0.
- count saturation never occurs by construction. An ack at a boundary is a design error covered by assertion.
- Consistency check, only in cycles with fifo_en=0 (no command in flight):
  - err sets if (fifo_full != (count==DEPTH)) or (fifo_empty != (count==0)).
  - err clears only on reset.
- All requests are sampled only in cycles where rst=1.

Decomposition:
- Shared package fifo_pkg holds:
  - constants FIFO_DW=4, FIFO_DEPTH=8, FIFO_CW=4;
  - enum req_id_t {REQ_W0, REQ_W1, REQ_RD} used for the rr pointer;
  - an opcode constant pair OP_READ=0/OP_WRITE=1 matching wnr polarity.
- One sub-module is natural: rr_arb3, a 3-way round-robin arbiter (eligible vector plus pointer in, one-hot grant plus next pointer out). The counter, command register, rd_valid pipeline and checker stay in fifo_access_ctrl.

Test Plan:
- Reset: rst=0 for 2 cycles with all reqs high -> all acks 0, fifo_en=0, count=0, err=0. Release -> W0 acked first.
- Fill: wr0_req=1 with data 1..8 sequentially, others idle -> 8 acks, fifo_d_in=1..8 on consecutive cycles, count reaches 8, fifo_full=1 and err=0. A 9th request gets no ack.
- Drain: rd_req=1 after fill -> rd_valid pulses on 8 consecutive cycles with rd_data 1,2,...,8 each two cycles after its ack. Then count=0, fifo_empty=1, further rd_ack=0.
- Fairness: all three requesting continuously from count=4 -> grant order W0,W1,R,W0,W1,R. Count nets +1 per 3 cycles until 8. Then only R is granted; count toggles 7/8 with writers alternating.
- Reset mid-operation: rst=0 in the cycle after a read ack -> rd_valid stays 0 and fifo_en=0 next cycle. After release, count=0 and the FIFO is empty.
- Checker: force fifo_empty=0 while count=0 and fifo_en=0 -> err=1 next cycle and stays 1 until rst=0.
